toggle_ff: RTL and testbench



---
 rtl/toggle_ff_pkg.sv | 12 +
 rtl/toggle_ff.sv | 50 +++++
 tb/tb_toggle_ff.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/toggle_ff_pkg.sv
// -----------------------------------------------------------------------------
// toggle_ff_pkg
//   Shared constants for the toggle flip-flop primitive.
//
//   TFF_DEFAULT_WIDTH : default number of independent toggle bits when the
//                       instantiating block does not override WIDTH.
// -----------------------------------------------------------------------------
package toggle_ff_pkg;

    localparam int unsigned TFF_DEFAULT_WIDTH = 1;

endpackage : toggle_ff_pkg

// File: rtl/toggle_ff.sv
// -----------------------------------------------------------------------------
// toggle_ff
//   Vector of independent T flip-flops sharing one clock, one asynchronous
//   active-high reset and one clock enable. On a rising clk edge with rst=0
//   and en=1, every bit whose t is high inverts; all other bits hold.
//   q is a pure register output: there is no combinational path from
//   t or en to q.
//
// Parameters:
//   WIDTH       - number of toggle bits (>= 1)
//   RESET_VALUE - value forced onto q while rst is high
//
// Ports:
//   clk  in   1      system clock, rising-edge active
//   rst  in   1      asynchronous active-high reset
//   en   in   1      clock enable; 0 holds every bit regardless of t
//   t    in   WIDTH  per-bit toggle request
//   q    out  WIDTH  registered state
// -----------------------------------------------------------------------------
module toggle_ff
    import toggle_ff_pkg::*;
#(
    parameter int unsigned           WIDTH       = TFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] w_toggle_mask;
    logic [WIDTH-1:0] r_q;

    // Enable gates every bit at once; XOR with the mask inverts exactly the
    // bits that were requested and leaves the rest untouched.
    assign w_toggle_mask = t & {WIDTH{en}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= r_q ^ w_toggle_mask;
        end
    end

    assign q = r_q;

endmodule : toggle_ff

// File: tb/tb_toggle_ff.sv
module tb_toggle_ff;

    localparam logic       RV1 = 1'b0;
    localparam logic [3:0] RV4 = 4'b1010;

    logic       clk;
    logic       rst1, en1;
    logic [0:0] t1;
    logic [0:0] q1;
    logic       rst4, en4;
    logic [3:0] t4;
    logic [3:0] q4;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    toggle_ff #(.WIDTH(1), .RESET_VALUE(RV1)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .en  (en1),
        .t   (t1),
        .q   (q1)
    );

    toggle_ff #(.WIDTH(4), .RESET_VALUE(RV4)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .en  (en4),
        .t   (t4),
        .q   (q4)
    );

    // ---------------- reference model ----------------
    // Each bit's value is its reset value XOR the parity of the number of
    // enabled toggle requests it has received since reset ended.
    int cnt1 = 0;
    int cnt4 [4] = '{0, 0, 0, 0};

    always @(posedge clk or posedge rst1) begin
        if (rst1) cnt1 <= 0;
        else if (en1 && t1[0]) cnt1 <= cnt1 + 1;
    end

    always @(posedge clk or posedge rst4) begin
        for (int i = 0; i < 4; i++) begin
            if (rst4) cnt4[i] <= 0;
            else if (en4 && t4[i]) cnt4[i] <= cnt4[i] + 1;
        end
    end

    function automatic logic [3:0] model_q1();
        logic [3:0] r;
        r = 4'b0;
        r[0] = rst1 ? RV1 : (RV1 ^ cnt1[0]);
        return r;
    endfunction

    function automatic logic [3:0] model_q4();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = rst4 ? RV4[i] : (RV4[i] ^ cnt4[i][0]);
        end
        return r;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst1 = 1'b1; en1 = 1'b0; t1 = 1'b0;
        rst4 = 1'b1; en4 = 1'b0; t4 = 4'b0000;

        // WIDTH=1 directed
        #3;  check("w1_reset_held",      {3'b0, q1}, 4'b0000);
        #7;  rst1 = 1'b0;
        #6;  check("w1_first_edge_idle", {3'b0, q1}, 4'b0000);
        #4;  en1 = 1'b1; t1 = 1'b1;
        #6;  check("w1_toggle_to_1",     {3'b0, q1}, 4'b0001);
        #4;  t1 = 1'b0;
        #6;  check("w1_hold_1",          {3'b0, q1}, 4'b0001);
        #4;  t1 = 1'b1;
        #6;  check("w1_toggle_to_0",     {3'b0, q1}, 4'b0000);
        #4;  t1 = 1'b0;
        #6;  check("w1_hold_0",          {3'b0, q1}, 4'b0000);
        #4;  en1 = 1'b0; t1 = 1'b1;
        #1;  check("w1_no_comb_path",    {3'b0, q1}, 4'b0000);
        #5;  check("w1_en_gated",        {3'b0, q1}, 4'b0000);
        en1 = 1'b1;
        #10; check("w1_set_before_rst",  {3'b0, q1}, 4'b0001);
        #2;  rst1 = 1'b1;
        #1;  check("w1_async_reset",     {3'b0, q1}, 4'b0000);
        #7;  check("w1_reset_over_edge", {3'b0, q1}, 4'b0000);
        #2;  rst1 = 1'b0;
        #8;  check("w1_square_1",        {3'b0, q1}, 4'b0001);
        #10; check("w1_square_0",        {3'b0, q1}, 4'b0000);
        #10; check("w1_square_1b",       {3'b0, q1}, 4'b0001);

        // WIDTH=4 directed
        check("w4_reset_value", q4, 4'b1010);
        #2;  rst4 = 1'b0; en4 = 1'b1; t4 = 4'b0011;
        #1;  check("w4_no_comb_path", q4, 4'b1010);
        #7;  check("w4_toggle_1001",  q4, 4'b1001);
        #10; check("w4_toggle_1010",  q4, 4'b1010);
        #2;  en4 = 1'b0;
        #8;  check("w4_hold_a",       q4, 4'b1010);
        #10; check("w4_hold_b",       q4, 4'b1010);
        // Reset arriving on the same timestep as a clock edge wins.
        en4 = 1'b1; t4 = 4'b1111;
        @(posedge clk);
        rst4 = 1'b1;
        #1;  check("w4_rst_at_edge",  q4, 4'b1010);
        #2;  rst4 = 1'b0;

        // Randomized phase against the model
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            check("rnd_w1", {3'b0, q1}, model_q1());
            check("rnd_w4", q4, model_q4());
            #1;
            rst1 = ($urandom_range(0, 15) == 0);
            rst4 = ($urandom_range(0, 15) == 0);
            en1  = 1'($urandom_range(0, 3) != 0);
            en4  = 1'($urandom_range(0, 3) != 0);
            t1   = 1'($urandom);
            t4   = 4'($urandom);
            #1;
            if (rst1) check("rnd_w1_async", {3'b0, q1}, {3'b0, RV1});
            if (rst4) check("rnd_w4_async", q4, RV4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_toggle_ff
